// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// dmem_mmio : data RAM plus MMIO page (cycle counter, LED, byte TX FIFO)
// Revision  : 1.0
// ============================================================================
module dmem_mmio #(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  LED,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_FW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_FW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_cycle;
  logic [7:0]      r_led;
  logic            r_ovf;
  logic [7:0]      r_buf [FIFO_DEPTH];
  logic [c_FW-1:0] r_rd;
  logic [c_FW-1:0] r_wr;
  logic [c_CW-1:0] r_count;

  logic w_ram_sel, w_per_sel, w_full, w_empty;
  logic w_push, w_pop, w_accept, w_ovf_set, w_ovf_clr, w_led_we;
  logic w_unused;

  assign w_ram_sel = (ALUResult[31:c_AW+2] == '0);
  assign w_per_sel = (ALUResult[31:4] == 28'h800_0000);
  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign w_led_we  = MemWrite && w_per_sel && (ALUResult[3:2] == 2'd1);
  assign w_push    = MemWrite && w_per_sel && (ALUResult[3:2] == 2'd2);
  assign w_ovf_clr = MemWrite && w_per_sel && (ALUResult[3:2] == 2'd3) && WriteData[2];
  assign w_pop     = !w_empty && TxReady;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_accept  = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && !w_accept;
  assign w_unused  = ^ALUResult[1:0];

  assign LED     = r_led;
  assign TxValid = !w_empty;
  assign TxData  = r_buf[r_rd];

  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_sel)
      r_mem[ALUResult[c_AW+1:2]] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
      r_led   <= '0;
      r_ovf   <= 1'b0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_buf[i] <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_led_we)
        r_led <= WriteData[7:0];
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_ovf_clr)
        r_ovf <= 1'b0;
      if (w_accept) begin
        r_buf[r_wr] <= WriteData[7:0];
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      r_count <= r_count + c_CW'(w_accept) - c_CW'(w_pop);
    end
  end

  always_comb begin
    ReadData = '0;
    if (w_ram_sel) begin
      ReadData = r_mem[ALUResult[c_AW+1:2]];
    end else if (w_per_sel) begin
      case (ALUResult[3:2])
        2'd0:    ReadData = r_cycle;
        2'd1:    ReadData = {24'b0, r_led};
        2'd3:    ReadData = {24'b0, 4'(r_count), 1'b0, r_ovf, w_full, w_empty};
        default: ReadData = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// tb_dmem_mmio : directed and randomized checks against a queue-based model
// Revision     : 1.0
// ============================================================================
module tb_dmem_mmio;

  localparam int DEPTH      = 64;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] c_CYC = 32'h8000_0000;
  localparam logic [31:0] c_LED = 32'h8000_0004;
  localparam logic [31:0] c_TX  = 32'h8000_0008;
  localparam logic [31:0] c_ST  = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [7:0]  LED;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady = 1'b0;

  dmem_mmio #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .LED(LED), .TxData(TxData),
    .TxValid(TxValid), .TxReady(TxReady)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, kept at the level of the programmer-visible behaviour
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_cycle;
  logic [7:0]  m_led;
  bit          m_ovf;
  logic [7:0]  m_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int reg_of(input logic [31:0] a);
    if (a >= c_CYC && a < c_CYC + 32'd16) return int'((a - c_CYC) / 4);
    return -1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(m_q.size()) * 16;
    if (m_ovf) s = s + 4;
    if (m_q.size() == FIFO_DEPTH) s = s + 2;
    if (m_q.size() == 0) s = s + 1;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < DEPTH * 4) return m_mem[a / 4];
    case (reg_of(a))
      0:       return m_cycle;
      1:       return {24'b0, m_led};
      3:       return model_status();
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cycle = '0;
    m_led   = '0;
    m_ovf   = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic rdy);
    bit was_full, pop, push;
    was_full = (m_q.size() == FIFO_DEPTH);
    pop      = (m_q.size() != 0) && rdy;
    push     = we && reg_of(a) == 2;
    if (we && a < DEPTH * 4) begin
      m_mem[a / 4]   = wd;
      m_known[a / 4] = 1'b1;
    end
    if (we && reg_of(a) == 1) m_led = wd[7:0];
    if (pop) void'(m_q.pop_front());
    if (push && (!was_full || pop)) m_q.push_back(wd[7:0]);
    if (push && was_full && !pop) m_ovf = 1'b1;
    else if (we && reg_of(a) == 3 && wd[2]) m_ovf = 1'b0;
    m_cycle = m_cycle + 1;
  endtask

  // Entered and left just after a falling edge; covers exactly one rising edge.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, output logic [31:0] rd, output logic [7:0] txd);
    MemWrite = we; ALUResult = a; WriteData = wd; TxReady = rdy;
    #1;
    rd  = ReadData;
    txd = TxData;
    if (a >= DEPTH * 4 || m_known[a / 4]) check("rdata", ReadData, model_read(a));
    check("txvalid", 32'(TxValid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("txdata", 32'(TxData), 32'(m_q[0]));
    check("led", 32'(LED), 32'(m_led));
    @(posedge clk);
    model_edge(we, a, wd, rdy);
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the immediate effect, releases at a falling edge.
  task automatic mid_reset();
    MemWrite = 1'b0; TxReady = 1'b1; ALUResult = c_ST;
    #2;
    reset = 1'b0;
    #1;
    check("rst_txvalid", 32'(TxValid), 32'h0);
    check("rst_txdata", 32'(TxData), 32'h0);
    check("rst_status", ReadData, 32'h1);
    check("rst_led", 32'(LED), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] rd;
  logic [7:0]  txd;
  logic [7:0]  drained [4];
  logic [31:0] a, wd;
  logic        we, rdy;

  initial begin
    model_reset();
    #1;
    check("por_txvalid", 32'(TxValid), 32'h0);
    check("por_led", 32'(LED), 32'h0);
    ALUResult = c_ST; #1;
    check("por_status", ReadData, 32'h1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b0, 32'h4000_0000, '0, 1'b0, rd, txd);
    check("bad_addr", rd, 32'h0);
    step(1'b0, c_CYC, '0, 1'b0, rd, txd);
    check("cycle10", rd, 32'd10);

    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, txd);
    step(1'b0, 32'h10, '0, 1'b0, rd, txd);
    check("ram_10", rd, 32'hDEAD_BEEF);
    step(1'b0, 32'h12, '0, 1'b0, rd, txd);
    check("ram_12", rd, 32'hDEAD_BEEF);

    step(1'b1, c_LED, 32'h1234_56A5, 1'b0, rd, txd);
    step(1'b0, c_LED, '0, 1'b0, rd, txd);
    check("led_rd", rd, 32'h0000_00A5);
    check("led_pin", 32'(LED), 32'hA5);

    step(1'b1, c_TX, 32'h11, 1'b0, rd, txd);
    step(1'b1, c_TX, 32'h22, 1'b0, rd, txd);
    step(1'b1, c_TX, 32'h33, 1'b0, rd, txd);
    step(1'b1, c_TX, 32'h44, 1'b0, rd, txd);
    step(1'b0, c_ST, '0, 1'b0, rd, txd);
    check("st_full", rd, 32'h42);
    step(1'b1, c_TX, 32'h55, 1'b0, rd, txd);
    step(1'b0, c_ST, '0, 1'b0, rd, txd);
    check("st_ovf", rd, 32'h46);
    step(1'b1, c_ST, 32'h4, 1'b0, rd, txd);
    step(1'b0, c_ST, '0, 1'b0, rd, txd);
    check("st_ovfclr", rd, 32'h42);

    step(1'b1, c_TX, 32'h66, 1'b1, rd, txd);
    check("pushpop_head", 32'(txd), 32'h11);
    step(1'b0, c_ST, '0, 1'b0, rd, txd);
    check("st_pushpop", rd, 32'h42);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h4000_0000, '0, 1'b1, rd, txd);
      drained[i] = txd;
    end
    check("drain0", 32'(drained[0]), 32'h22);
    check("drain1", 32'(drained[1]), 32'h33);
    check("drain2", 32'(drained[2]), 32'h44);
    check("drain3", 32'(drained[3]), 32'h66);
    step(1'b0, c_ST, '0, 1'b0, rd, txd);
    check("st_empty", rd, 32'h01);
    check("empty_valid", 32'(TxValid), 32'h0);

    step(1'b1, c_TX, 32'hA1, 1'b0, rd, txd);
    step(1'b1, c_TX, 32'hA2, 1'b0, rd, txd);
    step(1'b1, c_TX, 32'hA3, 1'b0, rd, txd);
    mid_reset();
    step(1'b1, c_TX, 32'h77, 1'b0, rd, txd);
    step(1'b0, c_ST, '0, 1'b0, rd, txd);
    check("post_rst_head", 32'(txd), 32'h77);
    check("post_rst_st", rd, 32'h10);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
        4:          a = c_CYC;
        5:          a = c_LED;
        6, 7:       a = c_TX;
        8:          a = c_ST;
        default:    a = ($urandom_range(0, 1) == 0) ? 32'h8000_0010 : 32'(DEPTH * 4);
      endcase
      we  = ($urandom_range(0, 1) == 1);
      wd  = $urandom;
      rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) mid_reset();
      else step(we, a, wd, rdy, rd, txd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
